// File: rtl/tqvp_prng_core_pkg.sv
// Shared definitions for the TinyQV PRNG peripheral: register addresses,
// CTRL/CMD bit positions and the default LFSR polynomial and seed.
// Imported by the LFSR sub-module and the top.
package tqvp_prng_core_pkg;

   // Register map (4-bit bridge address)
   localparam logic [3:0] ADDR_CTRL    = 4'h0;
   localparam logic [3:0] ADDR_CMD     = 4'h1;
   localparam logic [3:0] ADDR_SEED0   = 4'h4;
   localparam logic [3:0] ADDR_SEED1   = 4'h5;
   localparam logic [3:0] ADDR_SEED2   = 4'h6;
   localparam logic [3:0] ADDR_SEED3   = 4'h7;
   localparam logic [3:0] ADDR_SNAP0   = 4'h8;
   localparam logic [3:0] ADDR_SNAP1   = 4'h9;
   localparam logic [3:0] ADDR_SNAP2   = 4'hA;
   localparam logic [3:0] ADDR_SNAP3   = 4'hB;
   localparam logic [3:0] ADDR_STEPCNT = 4'hC;
   localparam logic [3:0] ADDR_DIV     = 4'hD;

   // CTRL bits
   localparam int CTRL_EN  = 0;
   localparam int CTRL_MIX = 1;
   localparam int CTRL_OE  = 2;

   // CMD bits
   localparam int CMD_STEP = 0;
   localparam int CMD_LOAD = 1;
   localparam int CMD_SNAP = 2;

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0] DEF_TAPS       = 32'h8020_0003;
   localparam logic [31:0] DEF_RESET_SEED = 32'h0000_0001;

endpackage

// File: rtl/tqvp_prng_core_if.sv
// Byte-wide register bus between the SPI register bridge and the PRNG.
// master = bridge (drives address/strobe/write data), slave = peripheral.
// Writes are single-cycle strobes; reads are combinational, no strobe.
interface tqvp_prng_core_if;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (output address, output data_write, output data_in, input data_out);
   modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_prng_core_lfsr32.sv
// 32-bit Galois LFSR state register with step, seed load and entropy mix.
// Latency: state updates on the edge after step/load; load beats step.
// No backpressure; state is forced to 1 whenever the next value would be 0.
// Ports: clk, rst_n, step, load, load_value[31:0], mix_bit, state[31:0].
module prng_lfsr32
   import tqvp_prng_core_pkg::*;
#(
   parameter logic [31:0] TAPS       = DEF_TAPS,
   parameter logic [31:0] RESET_SEED = DEF_RESET_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        mix_bit,
   output logic [31:0] state
);

   logic [31:0] state_nxt;

   always_comb begin
      state_nxt = state;
      if (load) begin
         state_nxt = load_value;
      end else if (step) begin
         state_nxt     = (state >> 1) ^ (state[0] ? TAPS : 32'h0);
         state_nxt[31] = state_nxt[31] ^ mix_bit;
      end
      // All-zero is a lock-up state for the LFSR; covers a zero seed as well
      // as a mixed step out of an (otherwise unreachable) zero state.
      if (state_nxt == 32'h0) begin
         state_nxt = 32'h1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RESET_SEED;
      end else begin
         state <= state_nxt;
      end
   end

endmodule

// File: rtl/tqvp_prng_core.sv
// TinyQV PRNG peripheral: register decode, free-run prescaler, snapshot, step counter.
// Latency: writes take effect on the strobe edge; data_out is combinational.
// No backpressure: every write strobe is accepted; reads have no side-effects.
// Ports: clk, rst_n, ui_in[7:0] (bit0 entropy), uo_out[7:0], bus (slave modport).
module tqvp_prng_core
   import tqvp_prng_core_pkg::*;
#(
   parameter logic [31:0] TAPS       = DEF_TAPS,
   parameter logic [31:0] RESET_SEED = DEF_RESET_SEED
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            ui_in,
   output logic [7:0]            uo_out,
   tqvp_prng_core_if.slave       bus
);

   logic [2:0]  ctrl;
   logic [7:0]  div;
   logic [7:0]  presc;
   logic [31:0] seed;
   logic [31:0] snap;
   logic [7:0]  stepcnt;
   logic [31:0] state;
   logic [7:0]  rd_dat;

   logic cmd_wr;
   logic cmd_step;
   logic cmd_load;
   logic cmd_snap;
   logic tick;
   logic step_req;
   logic step_applied;

   wire unused_ui = &{1'b0, ui_in[7:1]};

   assign cmd_wr   = bus.data_write && (bus.address == ADDR_CMD);
   assign cmd_step = cmd_wr && bus.data_in[CMD_STEP];
   assign cmd_load = cmd_wr && bus.data_in[CMD_LOAD];
   assign cmd_snap = cmd_wr && bus.data_in[CMD_SNAP];

   assign tick     = ctrl[CTRL_EN] && (presc == div);
   // A command step coinciding with a tick merges into one step; a seed load
   // suppresses the step entirely.
   assign step_req     = cmd_step || tick;
   assign step_applied = step_req && !cmd_load;

   prng_lfsr32 #(
      .TAPS       (TAPS),
      .RESET_SEED (RESET_SEED)
   ) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .step       (step_req),
      .load       (cmd_load),
      .load_value (seed),
      .mix_bit    (ctrl[CTRL_MIX] && ui_in[0]),
      .state      (state)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl    <= 3'h0;
         div     <= 8'h00;
         presc   <= 8'h00;
         seed    <= 32'h0;
         snap    <= 32'h0;
         stepcnt <= 8'h00;
      end else begin
         if (bus.data_write) begin
            case (bus.address)
               ADDR_CTRL:  ctrl        <= bus.data_in[2:0];
               ADDR_SEED0: seed[7:0]   <= bus.data_in;
               ADDR_SEED1: seed[15:8]  <= bus.data_in;
               ADDR_SEED2: seed[23:16] <= bus.data_in;
               ADDR_SEED3: seed[31:24] <= bus.data_in;
               ADDR_DIV:   div         <= bus.data_in;
               default: ;
            endcase
         end

         if (bus.data_write && (bus.address == ADDR_DIV)) begin
            presc <= 8'h00;
         end else if (!ctrl[CTRL_EN] || tick) begin
            presc <= 8'h00;
         end else begin
            presc <= presc + 8'd1;
         end

         // Snapshot sees the pre-edge state; a step on the same edge is the
         // first step of the new counting window.
         if (cmd_snap) begin
            snap    <= state;
            stepcnt <= step_applied ? 8'd1 : 8'd0;
         end else if (step_applied && (stepcnt != 8'hFF)) begin
            stepcnt <= stepcnt + 8'd1;
         end
      end
   end

   assign uo_out = ctrl[CTRL_OE] ? state[7:0] : 8'h00;

   always_comb begin
      rd_dat = 8'h00;
      case (bus.address)
         ADDR_CTRL:    rd_dat = {5'b0, ctrl};
         ADDR_SEED0:   rd_dat = seed[7:0];
         ADDR_SEED1:   rd_dat = seed[15:8];
         ADDR_SEED2:   rd_dat = seed[23:16];
         ADDR_SEED3:   rd_dat = seed[31:24];
         ADDR_SNAP0:   rd_dat = snap[7:0];
         ADDR_SNAP1:   rd_dat = snap[15:8];
         ADDR_SNAP2:   rd_dat = snap[23:16];
         ADDR_SNAP3:   rd_dat = snap[31:24];
         ADDR_STEPCNT: rd_dat = stepcnt;
         ADDR_DIV:     rd_dat = div;
         default:      rd_dat = 8'h00;
      endcase
   end

   assign bus.data_out = rd_dat;

endmodule

// File: tb/tb_tqvp_prng_core.sv
// Directed bench for tqvp_prng_core: register writes through the bus
// interface, expected values worked out by hand from the LFSR polynomial.
module tb_tqvp_prng_core;
   import tqvp_prng_core_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] uo_out;

   int checks;
   int failures;

   tqvp_prng_core_if bus();

   tqvp_prng_core dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      failures = failures + 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.data_in    = d;
      bus.data_write = 1'b1;
      @(negedge clk);
      bus.data_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.address = a;
      #1;
      d = bus.data_out;
   endtask

   task automatic rd_snap(output logic [31:0] v);
      logic [7:0] b;
      rd(ADDR_SNAP0, b); v[7:0]   = b;
      rd(ADDR_SNAP1, b); v[15:8]  = b;
      rd(ADDR_SNAP2, b); v[23:16] = b;
      rd(ADDR_SNAP3, b); v[31:24] = b;
   endtask

   task automatic wr_seed(input logic [31:0] s);
      wr(ADDR_SEED0, s[7:0]);
      wr(ADDR_SEED1, s[15:8]);
      wr(ADDR_SEED2, s[23:16]);
      wr(ADDR_SEED3, s[31:24]);
   endtask

   logic [7:0]  r8;
   logic [31:0] r32;

   initial begin
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      ui_in          = 8'h00;
      bus.address    = 4'h0;
      bus.data_in    = 8'h00;
      bus.data_write = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst_uo_out", {24'h0, uo_out}, 32'h00);
      rd(ADDR_CTRL, r8);    chk("rst_ctrl", {24'h0, r8}, 32'h00);
      rd(ADDR_DIV, r8);     chk("rst_div", {24'h0, r8}, 32'h00);
      rd(ADDR_STEPCNT, r8); chk("rst_stepcnt", {24'h0, r8}, 32'h00);
      rd_snap(r32);         chk("rst_snap", r32, 32'h0);
      wr(ADDR_CMD, 8'h04);
      rd_snap(r32);         chk("snap_reset_state", r32, 32'h0000_0001);
      rd(ADDR_STEPCNT, r8); chk("stepcnt_after_snap", {24'h0, r8}, 32'h00);
      rd(ADDR_CMD, r8);     chk("cmd_reads_zero", {24'h0, r8}, 32'h00);
      rd(4'h2, r8);         chk("unmapped_read", {24'h0, r8}, 32'h00);

      // Three manual steps: 1 -> 80200003 -> C0300002 -> 60180001
      wr(ADDR_CMD, 8'h01);
      wr(ADDR_CMD, 8'h04);
      rd_snap(r32);         chk("step1", r32, 32'h8020_0003);
      wr(ADDR_CMD, 8'h01);
      wr(ADDR_CMD, 8'h01);
      rd(ADDR_STEPCNT, r8); chk("stepcnt_2", {24'h0, r8}, 32'h02);
      wr(ADDR_CMD, 8'h04);
      rd_snap(r32);         chk("step3", r32, 32'h6018_0001);

      // Zero seed is replaced by 1
      wr_seed(32'h0);
      wr(ADDR_CMD, 8'h02);
      wr(ADDR_CMD, 8'h04);
      rd_snap(r32);         chk("zero_seed_guard", r32, 32'h0000_0001);
      rd(ADDR_STEPCNT, r8); chk("load_not_counted", {24'h0, r8}, 32'h00);

      // Seed load and uo_out
      wr_seed(32'hDEAD_BEEF);
      rd(ADDR_SEED3, r8);   chk("seed3_read", {24'h0, r8}, 32'hDE);
      chk("uo_out_oe_off", {24'h0, uo_out}, 32'h00);
      wr(ADDR_CMD, 8'h02);
      wr(ADDR_CTRL, 8'h04);
      chk("uo_out_seed", {24'h0, uo_out}, 32'hEF);
      wr(ADDR_CMD, 8'h01);  // DEADBEEF -> EF76DF74
      chk("uo_out_step", {24'h0, uo_out}, 32'h74);

      // All CMD bits at once: load wins, snapshot sees old state
      wr_seed(32'h1234_5678);
      wr(ADDR_CMD, 8'h07);
      rd_snap(r32);         chk("cmd7_snap_old", r32, 32'hEF76_DF74);
      chk("cmd7_load_no_step", {24'h0, uo_out}, 32'h78);
      rd(ADDR_STEPCNT, r8); chk("cmd7_stepcnt", {24'h0, r8}, 32'h00);

      // Snapshot with a coincident step: 12345678 -> 091A2B3C
      wr(ADDR_CMD, 8'h05);
      rd_snap(r32);         chk("cmd5_snap", r32, 32'h1234_5678);
      rd(ADDR_STEPCNT, r8); chk("cmd5_stepcnt_one", {24'h0, r8}, 32'h01);
      chk("cmd5_uo_out", {24'h0, uo_out}, 32'h3C);

      // Entropy mix: seed 2, one step with ui_in[0]=1 -> 80000001
      wr_seed(32'h0000_0002);
      wr(ADDR_CMD, 8'h02);
      wr(ADDR_CTRL, 8'h06);
      ui_in = 8'h01;
      wr(ADDR_CMD, 8'h01);
      ui_in = 8'h00;
      wr(ADDR_CMD, 8'h04);
      rd_snap(r32);         chk("mix_step", r32, 32'h8000_0001);
      rd(ADDR_CTRL, r8);    chk("ctrl_read", {24'h0, r8}, 32'h06);
      wr(ADDR_CTRL, 8'hF8);
      rd(ADDR_CTRL, r8);    chk("ctrl_upper_zero", {24'h0, r8}, 32'h00);

      // Free-run: DIV=3 gives a step every 4 clocks; 10 steps in 40 clocks
      wr(ADDR_CMD, 8'h04);
      wr(ADDR_DIV, 8'h03);
      rd(ADDR_DIV, r8);     chk("div_read", {24'h0, r8}, 32'h03);
      wr(ADDR_CTRL, 8'h01);
      repeat (39) @(negedge clk);
      wr(ADDR_CTRL, 8'h00);
      rd(ADDR_STEPCNT, r8); chk("freerun_stepcnt", {24'h0, r8}, 32'h0A);
      wr(ADDR_CMD, 8'h04);
      rd(ADDR_STEPCNT, r8); chk("freerun_snap_clear", {24'h0, r8}, 32'h00);
      wr(ADDR_CTRL, 8'h01);
      repeat (2000) @(negedge clk);
      wr(ADDR_CTRL, 8'h00);
      rd(ADDR_STEPCNT, r8); chk("stepcnt_saturate", {24'h0, r8}, 32'hFF);

      // Asynchronous reset in the middle of free-run
      wr(ADDR_DIV, 8'h00);
      wr(ADDR_CTRL, 8'h05);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_uo_out", {24'h0, uo_out}, 32'h00);
      bus.address = ADDR_CTRL;    #1; chk("arst_ctrl", {24'h0, bus.data_out}, 32'h00);
      bus.address = ADDR_DIV;     #1; chk("arst_div", {24'h0, bus.data_out}, 32'h00);
      bus.address = ADDR_STEPCNT; #1; chk("arst_stepcnt", {24'h0, bus.data_out}, 32'h00);
      bus.address = ADDR_SNAP3;   #1; chk("arst_snap3", {24'h0, bus.data_out}, 32'h00);
      bus.address = ADDR_SEED0;   #1; chk("arst_seed0", {24'h0, bus.data_out}, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      wr(ADDR_CMD, 8'h04);
      rd_snap(r32);         chk("arst_state_seed", r32, 32'h0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
